// File: rtl/audio_out_serializer.sv
// Left-justified stereo DAC serializer: stereo-pair FIFO on CLOCK_27, codec BCLK/LRCK
// synchronized and edge-detected, one pair popped per LRCK frame and shifted out MSB first.
module audio_out_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          CLOCK_27,
  input  logic                          reset,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  input  logic [DATA_WIDTH-1:0]         left_data,
  input  logic [DATA_WIDTH-1:0]         right_data,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          underflow,
  output logic                          AUD_DACDAT
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned PAIR_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} state_e;

  logic bclk_meta_q, bclk_sync_q, bclk_prev_q;
  logic lrck_meta_q, lrck_sync_q, lrck_smp_q;
  logic bclk_fall, lrck_rise, lrck_fall;

  logic [PAIR_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  fifo_empty, push, pop;
  logic [PAIR_W-1:0]     pop_word;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [BIT_W-1:0]      bitcnt_q, bitcnt_d;
  logic                  dac_q, dac_d;
  logic                  underflow_q;

  // LRCK is only meaningful at BCLK falling edges, so its history register is updated there
  assign bclk_fall = bclk_prev_q & ~bclk_sync_q;
  assign lrck_rise = bclk_fall & lrck_sync_q & ~lrck_smp_q;
  assign lrck_fall = bclk_fall & ~lrck_sync_q & lrck_smp_q;

  always_ff @(posedge CLOCK_27) begin
    if (reset) begin
      bclk_meta_q <= 1'b0;
      bclk_sync_q <= 1'b0;
      bclk_prev_q <= 1'b0;
      lrck_meta_q <= 1'b0;
      lrck_sync_q <= 1'b0;
      lrck_smp_q  <= 1'b0;
    end else begin
      bclk_meta_q <= AUD_BCLK;
      bclk_sync_q <= bclk_meta_q;
      bclk_prev_q <= bclk_sync_q;
      lrck_meta_q <= AUD_DACLRCK;
      lrck_sync_q <= lrck_meta_q;
      if (bclk_fall) lrck_smp_q <= lrck_sync_q;
    end
  end

  assign fifo_empty   = (count_q == '0);
  assign sample_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push         = sample_valid & sample_ready & ~reset;
  assign pop          = lrck_rise & ~fifo_empty;
  assign pop_word     = fifo_empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge CLOCK_27) begin
    if (push) mem_q[wr_ptr_q] <= {left_data, right_data};
  end

  always_ff @(posedge CLOCK_27) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLOCK_27) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      bitcnt_q    <= '0;
      dac_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      bitcnt_q    <= bitcnt_d;
      dac_q       <= dac_d;
      underflow_q <= underflow_q | (lrck_rise & fifo_empty);
    end
  end

  // Frame sequencing and shifter; each load presents the MSB immediately
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    hold_d   = hold_q;
    bitcnt_d = bitcnt_q;
    dac_d    = dac_q;
    if (lrck_rise && state_q != S_LEFT) begin
      state_d  = S_LEFT;
      dac_d    = pop_word[PAIR_W-1];
      shift_d  = pop_word[PAIR_W-1:DATA_WIDTH] << 1;
      hold_d   = pop_word[DATA_WIDTH-1:0];
      bitcnt_d = BIT_W'(1);
    end else if (lrck_fall && state_q == S_LEFT) begin
      state_d  = S_RIGHT;
      dac_d    = hold_q[DATA_WIDTH-1];
      shift_d  = hold_q << 1;
      bitcnt_d = BIT_W'(1);
    end else if (bclk_fall && state_q != S_IDLE) begin
      if (bitcnt_q < BIT_W'(DATA_WIDTH)) begin
        dac_d    = shift_q[DATA_WIDTH-1];
        shift_d  = shift_q << 1;
        bitcnt_d = bitcnt_q + BIT_W'(1);
      end else begin
        dac_d = 1'b0;
      end
    end else if (state_q == S_IDLE) begin
      dac_d = 1'b0;
    end
  end

  assign fifo_count = count_q;
  assign underflow  = underflow_q;
  assign AUD_DACDAT = dac_q;

endmodule

// File: tb/tb_audio_out_serializer.sv
// Directed bench for audio_out_serializer: acts as producer and as the codec, capturing
// AUD_DACDAT on BCLK rising edges and comparing against hand-computed words.
module tb_audio_out_serializer;

  logic        CLOCK_27 = 1'b0;
  logic        reset = 1'b1;
  logic        AUD_BCLK = 1'b1;
  logic        AUD_DACLRCK = 1'b0;
  logic [15:0] left_data = '0;
  logic [15:0] right_data = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [3:0]  fifo_count;
  logic        underflow;
  logic        AUD_DACDAT;

  int tests = 0;
  int fails = 0;

  audio_out_serializer #(.DATA_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .CLOCK_27    (CLOCK_27),
    .reset       (reset),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .left_data   (left_data),
    .right_data  (right_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .fifo_count  (fifo_count),
    .underflow   (underflow),
    .AUD_DACDAT  (AUD_DACDAT)
  );

  always #5 CLOCK_27 = ~CLOCK_27;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One BCLK period: LRCK changes with the falling edge, codec samples data at the rise
  task automatic bclk_cycle(input logic lr, input int half, output logic b);
    @(negedge CLOCK_27);
    AUD_BCLK    = 1'b0;
    AUD_DACLRCK = lr;
    repeat (half) @(negedge CLOCK_27);
    b = AUD_DACDAT;
    AUD_BCLK = 1'b1;
    repeat (half - 1) @(negedge CLOCK_27);
  endtask

  task automatic run_frame(input int half, output logic [31:0] lcap, output logic [31:0] rcap);
    logic b;
    lcap = '0;
    rcap = '0;
    for (int i = 0; i < 32; i++) begin
      bclk_cycle(1'b1, half, b);
      lcap = {lcap[30:0], b};
    end
    for (int i = 0; i < 32; i++) begin
      bclk_cycle(1'b0, half, b);
      rcap = {rcap[30:0], b};
    end
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    @(negedge CLOCK_27);
    sample_valid = 1'b1;
    left_data    = l;
    right_data   = r;
    @(negedge CLOCK_27);
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_27);
    reset        = 1'b1;
    sample_valid = 1'b0;
    AUD_BCLK     = 1'b1;
    AUD_DACLRCK  = 1'b0;
    repeat (3) @(negedge CLOCK_27);
    reset = 1'b0;
    @(negedge CLOCK_27);
  endtask

  vec_t        vecs[4];
  logic [31:0] lc, rc;
  logic        b, any_one;
  logic [4:0]  first_bits;
  int          pidx, mon_min, mon_max;
  logic        push_pend, prod_stop, mon_en;

  initial begin
    vecs[0] = '{16'hA5C3, 16'h0F0F, 32'hA5C3_0000, 32'h0F0F_0000};
    vecs[1] = '{16'h8000, 16'h7FFF, 32'h8000_0000, 32'h7FFF_0000};
    vecs[2] = '{16'hFFFF, 16'h0001, 32'hFFFF_0000, 32'h0001_0000};
    vecs[3] = '{16'h0000, 16'hFFFF, 32'h0000_0000, 32'hFFFF_0000};

    // Reset state, with sample_valid offered during reset
    sample_valid = 1'b1;
    left_data    = 16'hDEAD;
    right_data   = 16'hBEEF;
    repeat (4) @(negedge CLOCK_27);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_ready", 64'(sample_ready), 64'd1);
    check("rst_underflow", 64'(underflow), 64'd0);
    check("rst_dacdat", 64'(AUD_DACDAT), 64'd0);
    reset        = 1'b0;
    sample_valid = 1'b0;
    @(negedge CLOCK_27);
    check("rst_valid_ignored", 64'(fifo_count), 64'd0);

    // Table: push all pairs, then one frame per pair at 8 cycles per BCLK half
    for (int i = 0; i < 4; i++) push_pair(vecs[i].l, vecs[i].r);
    check("table_count", 64'(fifo_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      run_frame(8, lc, rc);
      check($sformatf("table_frame%0d", i), {lc, rc}, {vecs[i].exp_l, vecs[i].exp_r});
    end
    check("table_drained", 64'(fifo_count), 64'd0);
    check("table_no_underflow", 64'(underflow), 64'd0);

    // Full FIFO, pop while producer keeps offering, order across pointer wrap
    do_reset();
    pidx = 0; push_pend = 1'b0; prod_stop = 1'b0; mon_en = 1'b0;
    mon_min = 15; mon_max = 0;
    fork
      begin
        while (!prod_stop) begin
          @(negedge CLOCK_27);
          if (push_pend) pidx++;
          sample_valid = (pidx < 20);
          left_data    = 16'(16'h1000 + pidx);
          right_data   = 16'(16'h2000 + pidx);
          push_pend    = sample_valid && sample_ready;
          if (mon_en) begin
            if (int'(fifo_count) < mon_min) mon_min = int'(fifo_count);
            if (int'(fifo_count) > mon_max) mon_max = int'(fifo_count);
          end
        end
        sample_valid = 1'b0;
      end
      begin
        repeat (12) @(negedge CLOCK_27);
        check("full_count", 64'(fifo_count), 64'd8);
        check("full_ready", 64'(sample_ready), 64'd0);
        mon_en = 1'b1;
        for (int f = 0; f < 20; f++) begin
          run_frame(4, lc, rc);
          if (f == 0) begin
            mon_en = 1'b0;
            check("pop_full_min", 64'(mon_min), 64'd7);
            check("pop_full_max", 64'(mon_max), 64'd8);
            check("pop_full_refill", 64'(fifo_count), 64'd8);
          end
          check($sformatf("wrap_frame%0d", f), {lc, rc},
                {16'(16'h1000 + f), 16'h0000, 16'(16'h2000 + f), 16'h0000});
        end
        prod_stop = 1'b1;
      end
    join
    check("wrap_drained", 64'(fifo_count), 64'd0);
    check("wrap_no_underflow", 64'(underflow), 64'd0);

    // Underflow: two frames with nothing pushed
    do_reset();
    check("uf_before", 64'(underflow), 64'd0);
    bclk_cycle(1'b1, 8, b);
    check("uf_after_rise", 64'(underflow), 64'd1);
    any_one = b;
    for (int i = 1; i < 32; i++) begin
      bclk_cycle(1'b1, 8, b);
      any_one |= b;
    end
    for (int i = 0; i < 32; i++) begin
      bclk_cycle(1'b0, 8, b);
      any_one |= b;
    end
    run_frame(8, lc, rc);
    check("uf_data_zero", {63'd0, any_one} | {lc, rc}, 64'd0);
    check("uf_sticky", 64'(underflow), 64'd1);

    // Reset in the middle of a left word (underflow still set from above)
    push_pair(16'hA5C3, 16'h0F0F);
    push_pair(16'h1234, 16'h5678);
    first_bits = '0;
    for (int i = 0; i < 5; i++) begin
      bclk_cycle(1'b1, 8, b);
      first_bits = {first_bits[3:0], b};
    end
    check("mid_first_bits", 64'(first_bits), 64'h14);
    @(negedge CLOCK_27);
    AUD_BCLK = 1'b0;
    repeat (4) @(negedge CLOCK_27);
    check("mid_bit5", 64'(AUD_DACDAT), 64'd1);
    reset = 1'b1;
    @(negedge CLOCK_27);
    check("mid_rst_dacdat", 64'(AUD_DACDAT), 64'd0);
    check("mid_rst_count", 64'(fifo_count), 64'd0);
    check("mid_rst_underflow", 64'(underflow), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge CLOCK_27);
    any_one = AUD_DACDAT;
    AUD_BCLK = 1'b1;
    repeat (7) @(negedge CLOCK_27);
    for (int i = 6; i < 32; i++) begin
      bclk_cycle(1'b1, 8, b);
      any_one |= b;
    end
    bclk_cycle(1'b0, 8, b);
    any_one |= b;
    push_pair(16'h3C3C, 16'hC3C3);
    for (int i = 1; i < 32; i++) begin
      bclk_cycle(1'b0, 8, b);
      any_one |= b;
    end
    check("mid_quiet_after_rst", 64'(any_one), 64'd0);
    run_frame(8, lc, rc);
    check("mid_resume", {lc, rc}, {32'h3C3C_0000, 32'hC3C3_0000});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_out_serializer.md
AUDIO_OUT_SERIALIZER -- requirements
Module: audio_out_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning bits per channel sample (range 8..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning stereo-pair FIFO entries (power of 2, at least 2).
REQ-003 SHALL use one clock, CLOCK_27; reset is synchronous and active-high, port name reset.
REQ-004 SHALL have port CLOCK_27  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port AUD_BCLK  input  1  codec bit clock, asynchronous to CLOCK_27.
REQ-007 SHALL have port AUD_DACLRCK  input  1  codec DAC word clock, asynchronous; high = left channel.
REQ-008 SHALL have port left_data  input  DATA_WIDTH  left sample, two's complement.
REQ-009 SHALL have port right_data  input  DATA_WIDTH  right sample, two's complement.
REQ-010 SHALL have port sample_valid  input  1  producer offers a stereo pair.
REQ-011 SHALL have port sample_ready  output  1  FIFO can accept a pair.
REQ-012 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of pairs stored.
REQ-013 SHALL have port underflow  output  1  sticky flag: a frame started with the FIFO empty.
REQ-014 SHALL have port AUD_DACDAT  output  1  serial data to codec, left-justified format, MSB first.

Function
REQ-015 SHALL pass AUD_BCLK and AUD_DACLRCK through 2-flop synchronizers, then a third register for edge detection.
REQ-016 SHALL assert bclk_fall for exactly one cycle when synchronized BCLK goes 1->0; rising edges are ignored.
REQ-017 SHALL sample synchronized LRCK only on bclk_fall cycles; lrck_rise/lrck_fall = sampled value differs from value at previous bclk_fall.
REQ-018 SHALL require BCLK high and low phases of at least 4 CLOCK_27 cycles each; behaviour outside this is undefined.
REQ-019 SHALL write {left_data,right_data} into the FIFO on a cycle with sample_valid && sample_ready.
REQ-020 SHALL drive sample_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
REQ-021 SHALL pop one pair only on a bclk_fall cycle with lrck_rise and fifo_count != 0.
REQ-022 SHALL, on simultaneous push and pop, leave fifo_count unchanged and store the pushed pair; pointers wrap modulo FIFO_DEPTH.
REQ-023 SHALL NOT bypass: a pop in the same cycle as a push into an empty FIFO sees empty.
REQ-024 SHALL implement states IDLE, LEFT, RIGHT; IDLE->LEFT on lrck_rise, LEFT->RIGHT on lrck_fall, RIGHT->LEFT on lrck_rise; IDLE ignores lrck_fall.
REQ-025 SHALL, on entering LEFT, load left word into the shift register and latch right word into a holding register; zeros for both if FIFO empty.
REQ-026 SHALL, on entering RIGHT, load the holding register into the shift register.
REQ-027 SHALL set underflow on any lrck_rise with FIFO empty; cleared only by reset.
REQ-028 SHALL drive AUD_DACDAT from a register: MSB in the cycle after the loading bclk_fall, next bit after each subsequent bclk_fall.
REQ-029 SHALL count bits shifted; after DATA_WIDTH bits of a word, AUD_DACDAT = 0 until next load.
REQ-030 SHALL hold AUD_DACDAT = 0 in IDLE.

Reset
REQ-031 SHALL, while reset is high, force state IDLE, empty FIFO (fifo_count=0), sample_ready=1, underflow=0, AUD_DACDAT=0, shift/holding/bit-counter=0.
REQ-032 SHALL clear synchronizer and edge-detect registers to 0; a reset mid-frame discards the word in flight, outputs 0 until next lrck_rise.
REQ-033 SHALL ignore sample_valid during reset.

Verification
REQ-034 SHALL verify: push L=16'hA5C3, R=16'h0F0F, then BCLK 8 cycles/half, 32 BCLK per LRCK half -> codec-side capture on BCLK rise reads A5C3 left, 0F0F right, then 16 zero bits each.
REQ-035 SHALL verify: hold sample_valid high with no BCLK -> sample_ready drops after 8 pushes, fifo_count=8; 9th pair not stored.
REQ-036 SHALL verify: no pushes, run 2 frames -> AUD_DACDAT stays 0, underflow=1 after first lrck_rise, remains 1.
REQ-037 SHALL verify: FIFO full, push attempted on pop cycle -> count goes 8->7, then next push accepted, count 8; order preserved across pointer wrap over 20 pairs.
REQ-038 SHALL verify: reset asserted mid-left-word after 5 bits -> next cycle AUD_DACDAT=0, fifo_count=0, underflow=0; lrck_fall ignored; output resumes at next lrck_rise.
